toggle_resp: RTL and testbench

- Responder end of the two-phase (toggle) request/acknowledge protocol.
- A remote initiator flips `req_tgl` once per transfer, with `req_data` held stable. This block synchronizes the flip, detects it and presents the data on a local valid/ready port.
- After the local consumer accepts, it flips `ack_tgl` back to the initiator.
- Sits at the receive side of any clock-domain or block boundary built on toggle-flop signalling.

---
 rtl/toggle_pkg.sv | 7 +
 rtl/toggle_sync.sv | 18 +
 rtl/toggle_resp.sv | 81 ++++++++
 tb/tb_toggle_resp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// toggle_pkg: shared types and constants for the two-phase toggle handshake
package toggle_pkg;
    typedef enum logic {IDLE, VALID} resp_state_e;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int TOGGLE_DATA_W = 8;
    typedef logic [TOGGLE_DATA_W-1:0] toggle_payload_t;
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: N-stage reset-to-0 bit synchronizer for toggle signals
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;
    // shift the asynchronous input one stage per clock
    always_comb sync_d = {sync_q[STAGES-2:0], d};
    // chain flops
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/toggle_resp.sv
// toggle_resp: responder end of a toggle req/ack handshake with a valid/ready local port
module toggle_resp
    import toggle_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ack_tgl,
    output logic              busy,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic              err_ovr
);
    localparam int STAGES = SYNC_STAGES < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : SYNC_STAGES;
    resp_state_e       state_q, state_d;
    logic              req_seen_q, req_seen_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              ack_q, ack_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_sync, req_pend, take, accept;
    toggle_sync #(.STAGES(STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (req_tgl),
        .q    (req_sync)
    );
    assign req_pend = req_sync ^ req_seen_q;
    // next state: capture a pending flip in IDLE, release on accept; a flip seen while VALID is an overrun
    always_comb begin
        take        = state_q == IDLE && req_pend;
        accept      = state_q == VALID && out_ready;
        state_d     = take ? VALID : accept ? IDLE : state_q;
        req_seen_d  = take ? req_sync : req_seen_q;
        out_data_d  = take ? req_data : out_data_q;
        out_valid_d = take | (out_valid_q & ~accept);
        ack_d       = ack_q ^ accept;
        cnt_d       = cnt_q + CNT_W'(accept);
        err_d       = err_q | (state_q == VALID && req_pend);
    end
    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_seen_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_seen_q  <= req_seen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ack_tgl   = ack_q;
    assign busy      = state_q == VALID;
    assign evt_cnt   = cnt_q;
    assign err_ovr   = err_q;
    VALID_STABLE: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data));
    ACK_ON_ACCEPT: assert property (@(posedge clk) disable iff (!rst_n)
        $changed(ack_tgl) == $past(out_valid && out_ready));
    CNT_STEP: assert property (@(posedge clk) disable iff (!rst_n)
        $changed(evt_cnt) |-> evt_cnt == $past(evt_cnt) + 1'b1 && $changed(ack_tgl));
endmodule

// File: tb/tb_toggle_resp.sv
// tb_toggle_resp: directed self-checking bench for toggle_resp
module tb_toggle_resp;
    import toggle_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, req_tgl = 1'b0, out_ready = 1'b0;
    toggle_payload_t req_data = '0;
    logic out_valid, ack_tgl, busy, err_ovr;
    logic [7:0] out_data;
    logic [15:0] evt_cnt;
    logic v4, a4, b4, e4;
    logic [7:0] d4;
    logic [3:0] c4;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    toggle_resp dut (
        .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .ack_tgl(ack_tgl), .busy(busy), .evt_cnt(evt_cnt), .err_ovr(err_ovr)
    );

    toggle_resp #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
        .out_valid(v4), .out_data(d4), .out_ready(out_ready),
        .ack_tgl(a4), .busy(b4), .evt_cnt(c4), .err_ovr(e4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_tgl = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, ack_tgl, busy, err_ovr, out_data, evt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%0h want=0", {out_valid, ack_tgl, busy, err_ovr, out_data, evt_cnt});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_data = 8'hA5;
        req_tgl = ~req_tgl;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got=%0b want=0", out_valid); end
        tick();
        checks++;
        if ({out_valid, busy, out_data, ack_tgl} !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL t1_present got=%0h want=%0h", {out_valid, busy, out_data, ack_tgl}, {1'b1, 1'b1, 8'hA5, 1'b0});
        end
        tick();
        checks++;
        if ({out_valid, busy, ack_tgl} !== 3'b001 || evt_cnt !== 16'd1) begin
            errors++; $display("FAIL t1_accept valid/busy/ack=%0b cnt=%0d want 001 cnt=1", {out_valid, busy, ack_tgl}, evt_cnt);
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        req_data = 8'h3C;
        req_tgl = ~req_tgl;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, busy, out_data, ack_tgl} !== {1'b1, 1'b1, 8'h3C, 1'b1}) begin
                errors++; $display("FAIL t2_hold%0d got=%0h want=%0h", i, {out_valid, busy, out_data, ack_tgl}, {1'b1, 1'b1, 8'h3C, 1'b1});
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if ({out_valid, busy, out_data, ack_tgl} !== {1'b1, 1'b1, 8'h3C, 1'b1}) begin
            errors++; $display("FAIL t2_hold_last got=%0h want=%0h", {out_valid, busy, out_data, ack_tgl}, {1'b1, 1'b1, 8'h3C, 1'b1});
        end
        tick();
        checks++;
        if ({out_valid, busy, ack_tgl} !== 3'b000 || evt_cnt !== 16'd2) begin
            errors++; $display("FAIL t2_accept valid/busy/ack=%0b cnt=%0d want 000 cnt=2", {out_valid, busy, ack_tgl}, evt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic exp_ack;
        do_reset();
        out_ready = 1'b1;
        exp_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_data = 8'(i);
            req_tgl = ~req_tgl;
            wait_valid(n);
            checks++;
            if (n !== 3 || out_data !== 8'(i)) begin
                errors++; $display("FAIL t3_xfer%0d latency=%0d data=%0h want latency=3 data=%0h", i, n, out_data, i);
            end
            exp_ack = ~exp_ack;
            tick();
            checks++;
            if (ack_tgl !== exp_ack || out_valid !== 1'b0) begin
                errors++; $display("FAIL t3_ack%0d ack=%0b valid=%0b want ack=%0b valid=0", i, ack_tgl, out_valid, exp_ack);
            end
        end
        checks++;
        if (evt_cnt !== 16'd10 || ack_tgl !== 1'b0 || err_ovr !== 1'b0) begin
            errors++; $display("FAIL t3_final cnt=%0d ack=%0b err=%0b want cnt=10 ack=0 err=0", evt_cnt, ack_tgl, err_ovr);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        req_data = 8'h11;
        req_tgl = ~req_tgl;
        tick();
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, err_ovr} !== {1'b1, 8'h11, 1'b0}) begin
            errors++; $display("FAIL t4_first got=%0h want=%0h", {out_valid, out_data, err_ovr}, {1'b1, 8'h11, 1'b0});
        end
        req_data = 8'h22;
        req_tgl = ~req_tgl;
        tick();
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, err_ovr} !== {1'b1, 8'h11, 1'b1}) begin
            errors++; $display("FAIL t4_overrun got=%0h want=%0h", {out_valid, out_data, err_ovr}, {1'b1, 8'h11, 1'b1});
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, ack_tgl, err_ovr} !== 3'b011 || evt_cnt !== 16'd1) begin
            errors++; $display("FAIL t4_accept1 valid/ack/err=%0b cnt=%0d want 011 cnt=1", {out_valid, ack_tgl, err_ovr}, evt_cnt);
        end
        tick();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h22}) begin
            errors++; $display("FAIL t4_second got=%0h want=%0h", {out_valid, out_data}, {1'b1, 8'h22});
        end
        tick();
        tick();
        tick();
        checks++;
        if ({out_valid, ack_tgl, err_ovr} !== 3'b001 || evt_cnt !== 16'd2) begin
            errors++; $display("FAIL t4_final valid/ack/err=%0b cnt=%0d want 001 cnt=2", {out_valid, ack_tgl, err_ovr}, evt_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            req_data = 8'(i);
            req_tgl = ~req_tgl;
            tick();
            tick();
            tick();
            tick();
            if (i == 15) begin
                checks++;
                if (c4 !== 4'd0 || evt_cnt !== 16'd16) begin
                    errors++; $display("FAIL t5_wrap_zero c4=%0d cnt=%0d want c4=0 cnt=16", c4, evt_cnt);
                end
            end
        end
        checks++;
        if (c4 !== 4'd1 || evt_cnt !== 16'd17 || err_ovr !== 1'b0) begin
            errors++; $display("FAIL t5_wrap c4=%0d cnt=%0d err=%0b want c4=1 cnt=17 err=0", c4, evt_cnt, err_ovr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        req_tgl = 1'b1;
        tick();
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        req_data = 8'h77;
        req_tgl = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({out_valid, ack_tgl} !== 2'b11) begin
            errors++; $display("FAIL t6_setup valid/ack=%0b want 11", {out_valid, ack_tgl});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, ack_tgl, busy, out_data, evt_cnt, v4, a4, c4} !== '0) begin
            errors++; $display("FAIL t6_async_reset got=%0h want=0", {out_valid, ack_tgl, busy, out_data, evt_cnt, v4, a4, c4});
        end
        req_tgl = 1'b1;
        req_data = 8'h5A;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_early_valid got=%0b want=0", out_valid); end
        tick();
        checks++;
        if ({out_valid, out_data, ack_tgl} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++; $display("FAIL t6_new_xfer got=%0h want=%0h", {out_valid, out_data, ack_tgl}, {1'b1, 8'h5A, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_overrun();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
